aes_128_out_serializer: RTL and testbench
=========================================

Name: aes_128_out_serializer

Overview:
- Downstream stage of the multicycle aes_128 core.
- Captures each 128-bit ciphertext block the core presents on its output bus into a small block FIFO.
- Streams each block out as WORD_W-bit words over a valid/ready interface, most-significant word first.
- Decouples the core's one-block-every-~28-cycles cadence from a slower or stalling consumer.

Parameters:
- DEPTH, 2, number of 128-bit block entries in the FIFO; must be ≥1.
- WORD_W, 32, output word width; must divide 128. NW = 128/WORD_W words per block.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- blk_valid  in  1  one-cycle pulse from the core: blk_data holds a finished ciphertext block.
- blk_data  in  128  ciphertext block (core out_bus).
- blk_ready  out  1  at least one free FIFO entry (count < DEPTH).
- m_valid  out  1  output word available.
- m_data  out  WORD_W  current output word.
- m_last  out  1  current word is the final word (index NW-1) of its block.
- m_ready  in  1  consumer accepts m_data this cycle.
- overflow  out  1  sticky: a block arrived with no free entry.

Behaviour:
- State:
  - storage mem[DEPTH][128]
  - wr_ptr, rd_ptr: clog2(DEPTH) bits, wrap DEPTH-1 → 0 (explicit compare, DEPTH need not be a power of 2)
  - count: 0..DEPTH
  - word_idx: 0..NW-1
  - overflow flag
- Reset (async assert, sync-to-clk release):
  - all pointers, count, word_idx = 0; overflow = 0
  - m_valid = 0, m_last = 0, blk_ready = 1, m_data = 0
  - mem contents don't-care
- Write:
  - on an edge with blk_valid=1 and count<DEPTH: mem[wr_ptr] ← blk_data, wr_ptr++.
  - Accepted block visible on m_valid the cycle after the capturing edge (latency 1 when FIFO empty).
- Drop:
  - blk_valid=1 with count==DEPTH: block discarded, overflow ← 1 (held until reset).
  - Drop occurs even if the last word of the head block pops in the same cycle; blk_ready is defined by pre-edge count only.
- Output:
  - m_valid = (count != 0)
  - m_data = mem[rd_ptr][127 - WORD_W*word_idx -: WORD_W]; 0 when empty
  - m_last = m_valid && word_idx==NW-1
  - m_data/m_valid are stable while m_valid && !m_ready.
- Pop:
  - word handshake = m_valid && m_ready.
  - Not last: word_idx++.
  - Last: word_idx ← 0, rd_ptr++, count--.
- Simultaneous write + last-word pop (count<DEPTH): count unchanged, both pointers advance.
- blk_valid is treated as a pulse. Holding it high for k cycles with space writes k copies; this is the core's responsibility.
- m_ready while m_valid=0: ignored.
- Reset mid-block: partially sent block is lost; no resume.

Optional Feature:
- Macro: AES_OUT_BLK_CNT_EN.
- Defined:
  - adds output port blk_cnt [31:0]: count of blocks fully transmitted (last-word handshakes)
  - reset 0, wraps 0xFFFFFFFF → 0
  - increments on the same edge as the rd_ptr advance
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Single block (DEPTH=2, WORD_W=32, m_ready=1):
  - stimulus: blk_data=00112233_44556677_8899aabb_ccddeeff pulsed at edge N
  - response: m_valid from cycle N+1; words 00112233, 44556677, 8899aabb, ccddeeff on 4 consecutive cycles; m_last only on ccddeeff; m_valid=0 after.
- Backpressure:
  - stimulus: same block, m_ready toggling 1,0,0,1,…
  - response: m_data holds each word while stalled; exactly 4 handshakes; order unchanged.
- Full/overflow:
  - stimulus: m_ready=0, three blocks A, B, C pulsed 28 cycles apart
  - response: blk_ready=0 after B; C dropped, overflow=1; releasing m_ready yields A then B (8 words) and no C; overflow stays 1.
- Simultaneous write + pop:
  - stimulus: count=1, new block pulsed on the same edge as the last-word handshake
  - response: count stays 1; next word is the new block's word 0 with no idle cycle.
- Async reset mid-stream:
  - stimulus: rst_n=0 after word 2 of a block, between clock edges
  - response: m_valid, m_last, overflow go 0 immediately; blk_ready=1; after release a fresh block streams from word 0.
- AES_OUT_BLK_CNT_EN:
  - stimulus: 3 blocks fully drained
  - response: blk_cnt = 1, 2, 3, each incrementing on the edge of that block's m_last handshake.

Source files
------------

// File: rtl/aes_128_out_serializer.sv
// Captures 128-bit AES ciphertext blocks into a small block FIFO and streams them out MSW-first.
// Optional: define AES_OUT_BLK_CNT_EN to add blk_cnt, a count of fully transmitted blocks.
module aes_128_out_serializer #(
  parameter int DEPTH  = 2,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              blk_valid,
  input  logic [127:0]      blk_data,
  output logic              blk_ready,
  output logic              m_valid,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready,
  output logic              overflow
`ifdef AES_OUT_BLK_CNT_EN
  ,
  output logic [31:0]       blk_cnt
`endif
);

  localparam int NW    = 128 / WORD_W;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;

  logic [127:0]      mem [DEPTH];
  logic [WORD_W-1:0] words [NW];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] word_idx_q, word_idx_d;
  logic             overflow_q, overflow_d;
`ifdef AES_OUT_BLK_CNT_EN
  logic [31:0]      blk_cnt_q, blk_cnt_d;
`endif

  logic push;
  logic pop_word;
  logic pop_last;
  logic idx_at_last;

  // Slice the head entry into words once; word_idx then selects among them.
  for (genvar gi = 0; gi < NW; gi++) begin : g_words
    assign words[gi] = mem[rd_ptr_q][127 - WORD_W*gi -: WORD_W];
  end

  assign idx_at_last = (word_idx_q == IDX_W'(NW - 1));
  assign blk_ready   = (count_q != CNT_W'(DEPTH));
  assign m_valid     = (count_q != '0);
  assign m_last      = m_valid && idx_at_last;
  assign m_data      = m_valid ? words[word_idx_q] : '0;
  assign overflow    = overflow_q;
`ifdef AES_OUT_BLK_CNT_EN
  assign blk_cnt     = blk_cnt_q;
`endif

  // Acceptance depends only on pre-edge occupancy, so a same-cycle final pop does not rescue a block.
  assign push     = blk_valid && blk_ready;
  assign pop_word = m_valid && m_ready;
  assign pop_last = pop_word && idx_at_last;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    overflow_d = overflow_q | (blk_valid & ~blk_ready);
`ifdef AES_OUT_BLK_CNT_EN
    blk_cnt_d  = blk_cnt_q;
`endif

    if (push) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    end

    if (pop_word) begin
      if (pop_last) begin
        word_idx_d = '0;
        rd_ptr_d   = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
`ifdef AES_OUT_BLK_CNT_EN
        blk_cnt_d  = blk_cnt_q + 32'd1;
`endif
      end else begin
        word_idx_d = word_idx_q + IDX_W'(1);
      end
    end

    if (push && !pop_last) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop_last) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      word_idx_q <= '0;
      overflow_q <= 1'b0;
`ifdef AES_OUT_BLK_CNT_EN
      blk_cnt_q  <= '0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      overflow_q <= overflow_d;
`ifdef AES_OUT_BLK_CNT_EN
      blk_cnt_q  <= blk_cnt_d;
`endif
    end
  end

  // Storage carries no reset; contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= blk_data;
    end
  end

endmodule

// File: tb/tb_aes_128_out_serializer.sv
// Scoreboard bench for aes_128_out_serializer (DEPTH=2, WORD_W=32): stimulus pushes expected words, a monitor pops them.
module tb_aes_128_out_serializer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         blk_valid = 1'b0;
  logic [127:0] blk_data = '0;
  logic         blk_ready;
  logic         m_valid;
  logic [31:0]  m_data;
  logic         m_last;
  logic         m_ready = 1'b0;
  logic         overflow;
`ifdef AES_OUT_BLK_CNT_EN
  logic [31:0]  blk_cnt;
`endif

  aes_128_out_serializer #(.DEPTH(2), .WORD_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .overflow  (overflow)
`ifdef AES_OUT_BLK_CNT_EN
    ,
    .blk_cnt   (blk_cnt)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] BLK_A = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] BLK_B = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] BLK_C = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] BLK_D = 128'ha5a5a5a5_5a5a5a5a_0f0f0f0f_f0f0f0f0;
  localparam logic [127:0] BLK_E = 128'h01020304_05060708_090a0b0c_0d0e0f10;
  localparam logic [127:0] BLK_F = 128'hfeedface_baadf00d_12345678_9abcdef0;
  localparam logic [127:0] BLK_G = 128'h0badc0de_13579bdf_2468ace0_76543210;

  logic [32:0] sb [$];
  int n_checks = 0;
  int n_pass   = 0;
  int hs_count = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic push_block(input logic [127:0] d);
    for (int i = 0; i < 4; i++) sb.push_back({(i == 3), d[127 - 32*i -: 32]});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] d, input bit accept);
    blk_valid = 1'b1;
    blk_data  = d;
    if (accept) push_block(d);
    tick();
    blk_valid = 1'b0;
  endtask

  task automatic drain(input bit bp, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (bp) m_ready = ((k % 4) == 0) || ((k % 4) == 3);
      tick();
      if (sb.size() == 0) break;
    end
    m_ready = 1'b1;
    check("drain_left", 128'(sb.size()), 128'd0);
    check("idle_after_drain", 128'(m_valid), 128'd0);
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready) begin
      hs_count++;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL extra_word: got %h last %0b expected no word", m_data, m_last);
      end else begin
        logic [32:0] e;
        e = sb.pop_front();
        $display("word %h last %0b (expected %h last %0b)", m_data, m_last, e[31:0], e[32]);
        check("word", {95'd0, m_last, m_data}, {95'd0, e});
      end
    end
  end

  initial begin
    int base;
    #1;
    check("rst_m_valid", 128'(m_valid), 128'd0);
    check("rst_m_last", 128'(m_last), 128'd0);
    check("rst_blk_ready", 128'(blk_ready), 128'd1);
    check("rst_overflow", 128'(overflow), 128'd0);
    check("rst_m_data", 128'(m_data), 128'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single block, consumer always ready: visible one cycle after capture.
    m_ready = 1'b1;
    base = hs_count;
    send(BLK_A, 1'b1);
    check("lat1_valid", 128'(m_valid), 128'd1);
    check("lat1_word0", 128'(m_data), 128'h00112233);
    drain(1'b0, 20);
    check("single_hs", 128'(hs_count - base), 128'd4);

    // Backpressure pattern 1,0,0,1.
    m_ready = 1'b0;
    base = hs_count;
    send(BLK_A, 1'b1);
    drain(1'b1, 60);
    check("bp_hs", 128'(hs_count - base), 128'd4);

    // Fill, then overflow on the third block.
    m_ready = 1'b0;
    base = hs_count;
    send(BLK_B, 1'b1);
    repeat (27) tick();
    send(BLK_C, 1'b1);
    check("full_blk_ready", 128'(blk_ready), 128'd0);
    check("full_overflow_pre", 128'(overflow), 128'd0);
    repeat (27) tick();
    send(BLK_D, 1'b0);
    check("drop_overflow", 128'(overflow), 128'd1);
    check("drop_blk_ready", 128'(blk_ready), 128'd0);
    m_ready = 1'b1;
    drain(1'b0, 40);
    check("full_hs", 128'(hs_count - base), 128'd8);
    check("overflow_sticky", 128'(overflow), 128'd1);

    // New block written on the same edge as the head block's last handshake.
    m_ready = 1'b1;
    send(BLK_D, 1'b1);
    for (int k = 0; k < 10 && !m_last; k++) tick();
    check("reach_last", 128'(m_last), 128'd1);
    send(BLK_E, 1'b1);
    check("sim_valid", 128'(m_valid), 128'd1);
    check("sim_word0", 128'(m_data), 128'h01020304);
    check("sim_last", 128'(m_last), 128'd0);
    check("sim_blk_ready", 128'(blk_ready), 128'd1);
    drain(1'b0, 20);
`ifdef AES_OUT_BLK_CNT_EN
    check("blk_cnt_pre_reset", 128'(blk_cnt), 128'd6);
`endif

    // Asynchronous reset after two words of a block.
    base = hs_count;
    send(BLK_F, 1'b1);
    for (int k = 0; k < 10 && (hs_count - base) < 2; k++) tick();
    check("mid_hs", 128'(hs_count - base), 128'd2);
    #2;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("arst_m_valid", 128'(m_valid), 128'd0);
    check("arst_m_last", 128'(m_last), 128'd0);
    check("arst_overflow", 128'(overflow), 128'd0);
    check("arst_blk_ready", 128'(blk_ready), 128'd1);
`ifdef AES_OUT_BLK_CNT_EN
    check("arst_blk_cnt", 128'(blk_cnt), 128'd0);
`endif
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", 128'(m_valid), 128'd0);
    send(BLK_G, 1'b1);
    check("post_rst_word0", 128'(m_data), 128'h0badc0de);
    drain(1'b0, 20);
`ifdef AES_OUT_BLK_CNT_EN
    check("blk_cnt_1", 128'(blk_cnt), 128'd1);
    send(BLK_A, 1'b1);
    drain(1'b0, 20);
    check("blk_cnt_2", 128'(blk_cnt), 128'd2);
    send(BLK_B, 1'b1);
    drain(1'b0, 20);
    check("blk_cnt_3", 128'(blk_cnt), 128'd3);
`endif

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
